// File: rtl/operand_decode_stage.sv
// RV32I operand-B decode stage: opcode decode, immediate extension and operand-B
// pre-mux, registered into a single ID/EX entry with valid/ready handshake and flush.
module operand_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            alu_src,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] pc_q,
  output logic [4:0]      rd_addr,
  output logic [2:0]      funct3,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            dec_src;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_op_b;
  logic            xfer;

  logic            out_valid_d, out_valid_q;
  logic            alu_src_d, alu_src_q;
  logic            illegal_d, illegal_q;
  logic [4:0]      rd_addr_d, rd_addr_q;
  logic [2:0]      funct3_d, funct3_q;
  logic [XLEN-1:0] imm_ext_d, imm_ext_q;
  logic [XLEN-1:0] op_a_d, op_a_q;
  logic [XLEN-1:0] op_b_d, op_b_q;
  logic [XLEN-1:0] rs2_data_d, rs2_data_q;
  logic [XLEN-1:0] pc_d;

  assign opcode = instr[6:0];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shifts in OP-IMM take the plain I value; execute only looks at imm_ext[4:0].
  always_comb begin
    dec_src = 1'b0;
    dec_ill = 1'b0;
    dec_imm = '0;
    unique case (opcode)
      OPC_OP:     ;
      OPC_OP_IMM,
      OPC_LOAD,
      OPC_JALR:   begin dec_src = 1'b1; dec_imm = imm_i; end
      OPC_STORE:  begin dec_src = 1'b1; dec_imm = imm_s; end
      OPC_BRANCH: dec_imm = imm_b;
      OPC_LUI,
      OPC_AUIPC:  begin dec_src = 1'b1; dec_imm = imm_u; end
      OPC_JAL:    begin dec_src = 1'b1; dec_imm = imm_j; end
      default:    dec_ill = 1'b1;
    endcase
  end

  assign dec_op_b = dec_src ? dec_imm : rd2;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    if (flush)          out_valid_d = 1'b0;
    else if (xfer)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;
  end

  always_comb begin
    alu_src_d  = alu_src_q;
    illegal_d  = illegal_q;
    rd_addr_d  = rd_addr_q;
    funct3_d   = funct3_q;
    imm_ext_d  = imm_ext_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rs2_data_d = rs2_data_q;
    pc_d       = pc_q;
    if (xfer) begin
      alu_src_d  = dec_src;
      illegal_d  = dec_ill;
      rd_addr_d  = instr[11:7];
      funct3_d   = instr[14:12];
      imm_ext_d  = dec_imm;
      op_a_d     = rd1;
      op_b_d     = dec_op_b;
      rs2_data_d = rd2;
      pc_d       = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_src_q   <= 1'b0;
      illegal_q   <= 1'b0;
      rd_addr_q   <= '0;
      funct3_q    <= '0;
      imm_ext_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rs2_data_q  <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_src_q   <= alu_src_d;
      illegal_q   <= illegal_d;
      rd_addr_q   <= rd_addr_d;
      funct3_q    <= funct3_d;
      imm_ext_q   <= imm_ext_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rs2_data_q  <= rs2_data_d;
      pc_q        <= pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_src   = alu_src_q;
  assign illegal   = illegal_q;
  assign rd_addr   = rd_addr_q;
  assign funct3    = funct3_q;
  assign imm_ext   = imm_ext_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign rs2_data  = rs2_data_q;

endmodule

// File: tb/tb_operand_decode_stage.sv
// Scoreboard bench for operand_decode_stage: expected entries are queued at
// acceptance and compared against the registered outputs when consumed.
module tb_operand_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, pc, rd1, rd2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        alu_src;
  logic [31:0] imm_ext, op_a, op_b, rs2_data, pc_q;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic        illegal;

  typedef struct packed {
    logic        ov;
    logic        src;
    logic        ill;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] rs2;
    logic [31:0] pcv;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  operand_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rd1(rd1), .rd2(rd2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_src(alu_src),
    .imm_ext(imm_ext), .op_a(op_a), .op_b(op_b), .rs2_data(rs2_data),
    .pc_q(pc_q), .rd_addr(rd_addr), .funct3(funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ent_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    logic signed [31:0] si;
    logic [31:0] imm;
    logic src, ill;
    si  = i;
    imm = 32'h0;
    src = 1'b0;
    ill = 1'b0;
    case (i[6:0])
      7'h33: ;
      7'h13, 7'h03, 7'h67: begin src = 1'b1; imm = si >>> 20; end
      7'h23: begin src = 1'b1; imm = ((si >>> 20) & ~32'h1F) | {27'h0, i[11:7]}; end
      7'h63: imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: begin src = 1'b1; imm = i & 32'hFFFF_F000; end
      7'h6F: begin src = 1'b1; imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      default: ill = 1'b1;
    endcase
    e.ov  = 1'b1;
    e.src = src;
    e.ill = ill;
    e.rd  = i[11:7];
    e.f3  = i[14:12];
    e.imm = imm;
    e.opa = a;
    e.opb = src ? imm : b;
    e.rs2 = b;
    e.pcv = p;
    return e;
  endfunction

  function automatic ent_t snap();
    return {out_valid, alu_src, illegal, rd_addr, funct3, imm_ext, op_a, op_b, rs2_data, pc_q};
  endfunction

  // Drive one beat starting just after a falling edge; queue it if it will be accepted.
  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; instr = i; pc = p; rd1 = a; rd2 = b;
    #1;
    if (in_ready && !flush) sb.push_back(model(i, p, a, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    ent_t act;
    #1;
    act = snap();
    n_cmp++;
    if (act !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", act);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [7] = '{32'hFFF00093, 32'h002081B3, 32'h0020A423, 32'hFE208EE3,
                                 32'h123452B7, 32'hFF9FF06F, 32'h0000007F};
    logic [31:0] v_imm   [7] = '{32'hFFFFFFFF, 32'h0, 32'h8, 32'hFFFFFFFC,
                                 32'h12345000, 32'hFFFFFFF8, 32'h0};
    logic        v_src   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        v_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_opb   [7] = '{32'hFFFFFFFF, 32'hAA, 32'h8, 32'hAA,
                                 32'h12345000, 32'hFFFFFFF8, 32'hAA};
    ent_t exp, act;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      send(v_instr[k], 32'h100 + 32'(4 * k), 32'h11 + 32'(k), 32'hAA);
      act = snap();
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++; $display("FAIL decode_sb_empty[%0d]: got empty queue want entry", k);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          n_err++; $display("FAIL decode_entry[%0d]: got %h want %h", k, act, exp);
        end
      end
      n_cmp++;
      if ({alu_src, illegal, imm_ext, op_b} !== {v_src[k], v_ill[k], v_imm[k], v_opb[k]}) begin
        n_err++;
        $display("FAIL decode_const[%0d]: got src=%b ill=%b imm=%h opb=%h want src=%b ill=%b imm=%h opb=%h",
                 k, alu_src, illegal, imm_ext, op_b, v_src[k], v_ill[k], v_imm[k], v_opb[k]);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL decode_last_valid: got %b want 1", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL decode_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    ent_t held, exp, act;
    out_ready = 1'b1;
    send(32'h00500113, 32'h200, 32'h1, 32'h2);
    held = snap();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0020A423; pc = 32'h204; rd1 = 32'h3; rd2 = 32'h4;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready);
      end
      @(negedge clk);
      act = snap();
      n_cmp++;
      if (act !== held) begin
        n_err++; $display("FAIL bp_frozen[%0d]: got %h want %h", c, act, held);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    act = snap();
    exp = sb.pop_front();
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL bp_old_entry: got %h want %h", act, exp);
    end
    sb.push_back(model(instr, pc, rd1, rd2));
    @(negedge clk);
    in_valid = 1'b0;
    act = snap();
    exp = sb.pop_front();
    n_cmp++;
    if (act !== exp) begin
      n_err++; $display("FAIL bp_new_entry: got %h want %h", act, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] r;
    ent_t exp, act;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      r = $urandom();
      send({r[31:7], ops[k % 10]}, $urandom(), $urandom(), $urandom());
      act = snap();
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++; $display("FAIL b2b_sb_empty[%0d]: got empty queue want entry", k);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          n_err++; $display("FAIL b2b_entry[%0d]: got %h want %h", k, act, exp);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    flush = 1'b1;
    send(32'hFFF00093, 32'h300, 32'h5, 32'h6);
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_accept: got out_valid=%b want 0", out_valid);
    end
    send(32'h123452B7, 32'h304, 32'h7, 32'h8);
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_err++; $display("FAIL flush_stall_pre: got valid,ready=%b%b want 10", out_valid, in_ready);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_stall_post: got valid,ready=%b%b want 01", out_valid, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    ent_t act;
    out_ready = 1'b1;
    send(32'hFF9FF06F, 32'h400, 32'h9, 32'hA);
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    act = snap();
    n_cmp++;
    if (act !== '0) begin
      n_err++; $display("FAIL async_reset_outputs: got %h want 0", act);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; rd1 = '0; rd2 = '0;
    flush = 1'b0; out_ready = 1'b0;
    test_reset();
    test_decode();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_decode_stage.md
# operand_decode_stage

Decode-side producer of the ALU operand-B source select and extended immediate for the RV32I core. It sits between register-file read and the execute stage. Each cycle it decodes the instruction opcode and generates the sign-extended immediate for the format. It drives `alu_src` (0 = RD2, 1 = EXTEND) and the pre-muxed operand B. All results are registered into a single ID/EX stage with valid/ready handshake and flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction/operands on inputs are valid.
- `in_ready` out 1: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `instr` in 32: raw instruction word.
- `pc` in XLEN: instruction address.
- `rd1` in XLEN: rs1 register-file data.
- `rd2` in XLEN: rs2 register-file data.
- `flush` in 1: kill the held entry and any same-cycle acceptance.
- `out_valid` out 1: registered outputs are valid.
- `out_ready` in 1: execute stage consumes the entry when `out_valid && out_ready`.
- `alu_src` out 1: 0 = RD2, 1 = EXTEND.
- `imm_ext` out XLEN: extended immediate.
- `op_a` out XLEN: registered `rd1`.
- `op_b` out XLEN: `alu_src ? imm_ext : rd2`, registered.
- `rs2_data` out XLEN: registered `rd2`, always passed through for stores and branches.
- `pc_q` out XLEN: registered `pc`.
- `rd_addr` out 5: `instr[11:7]`.
- `funct3` out 3: `instr[14:12]`.
- `illegal` out 1: opcode not in the RV32I table below.

## Operation
- Opcode `instr[6:0]` decode gives `alu_src` and the immediate format:
  - 0110011 R: src 0, imm 0.
  - 0010011 OP-IMM: src 1, I-format.
  - 0000011 LOAD: src 1, I-format.
  - 1100111 JALR: src 1, I-format.
  - 0100011 STORE: src 1, S-format.
  - 1100011 BRANCH: src 0, B-format (imm still produced, used for the target).
  - 0110111 LUI: src 1, U-format.
  - 0010111 AUIPC: src 1, U-format.
  - 1101111 JAL: src 1, J-format.
  - Any other opcode: `illegal`=1, src 0, imm 0.
- Immediate formats; all are sign-extended from `instr[31]`:
  - I = `instr[31:20]`.
  - S = `{instr[31:25], instr[11:7]}`.
  - B = `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U = `{instr[31:12], 12'b0}`, no extension needed.
  - J = `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- OP-IMM shifts (funct3 001/101) use the plain I-format value. Downstream uses `imm_ext[4:0]`.
- Single-entry pipeline register:
  - `in_ready = !out_valid || out_ready`. This is combinational and must not depend on `in_valid`.
  - On transfer, all data outputs load from the decode of the current inputs.
  - When there is no transfer, data outputs hold.
- `out_valid` next value, in priority order:
  - `flush` → 0.
  - else transfer → 1.
  - else `out_ready` → 0.
  - else hold.
- Data registers do not need clearing on flush; consumers qualify everything with `out_valid`.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`.
- Throughput is 1 instruction/cycle when `out_ready` is held high.
- Reset (`rst_n` low, asynchronous): `out_valid`=0, `alu_src`=0, `illegal`=0, `rd_addr`=0, `funct3`=0, and all XLEN outputs = 0. `in_ready`=1 while in reset.
- Back-pressure: with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and every output is stable until consumed.
- Simultaneous consume and accept in the same cycle: new entry replaces the old, `out_valid` stays 1, no bubble.
- `flush` together with `in_valid && in_ready`: the incoming instruction is dropped and `out_valid`=0 next cycle.
- `flush` while stalled: the entry is discarded and `in_ready`=1 the following cycle.
- Reset asserted mid-stall: the entry is lost and `out_valid`=0 immediately (asynchronously).

## Test plan
- Accept `addi x1,x0,-1` (0xFFF00093) → next cycle `out_valid`=1, `alu_src`=1, `imm_ext`=0xFFFFFFFF, `op_b`=0xFFFFFFFF, `rd_addr`=1.
- `add x3,x1,x2` (0x002081B3) with `rd2`=0x0000_00AA → `alu_src`=0, `op_b`=0xAA, `imm_ext`=0, `rd_addr`=3.
- Immediate-format sweep:
  - `sw x2,8(x1)` (0x0020A423) → `alu_src`=1, `imm_ext`=8.
  - `beq x1,x2,-4` (0xFE208EE3) → `alu_src`=0, `imm_ext`=0xFFFFFFFC.
  - `lui x5,0x12345` (0x123452B7) → `imm_ext`=0x12345000.
  - `jal x0,-8` (0xFF9FF06F) → `imm_ext`=0xFFFFFFF8.
- Opcode 0x7F → `illegal`=1, `alu_src`=0, `imm_ext`=0.
- Back-pressure:
  - Hold `out_ready`=0 for 3 cycles with a new `in_valid` → `in_ready`=0 and outputs frozen.
  - Release → consume and accept in the same cycle, new entry visible next cycle, no bubble.
- Flush and reset:
  - Assert `flush` with `in_valid`=1 → `out_valid`=0 next cycle.
  - Pulse `rst_n` low mid-stall → all outputs 0 asynchronously.
